// File: rtl/dca_lsu_inst_arbiter_if.sv
// Handshake bundle between the DCA requesters and the shared matrix LSU.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
`ifndef BW_DCA_MATRIX_LSU_INST
`define BW_DCA_MATRIX_LSU_INST 32
`endif

interface dca_lsu_inst_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int BW_INST = `BW_DCA_MATRIX_LSU_INST
);
  logic [NUM_REQ-1:0]         req_inst_wvalid;
  logic [NUM_REQ-1:0]         req_inst_wready;
  logic [NUM_REQ*BW_INST-1:0] req_inst_wdata;
  logic [NUM_REQ-1:0]         req_done;
  logic                       lsu_inst_wvalid;
  logic                       lsu_inst_wready;
  logic [BW_INST-1:0]         lsu_inst_wdata;
  logic                       lsu_done;

  modport slave (
    input  req_inst_wvalid,
    input  req_inst_wdata,
    input  lsu_inst_wready,
    input  lsu_done,
    output req_inst_wready,
    output req_done,
    output lsu_inst_wvalid,
    output lsu_inst_wdata
  );

  modport master (
    output req_inst_wvalid,
    output req_inst_wdata,
    output lsu_inst_wready,
    output lsu_done,
    input  req_inst_wready,
    input  req_done,
    input  lsu_inst_wvalid,
    input  lsu_inst_wdata
  );
endinterface

// File: rtl/dca_lsu_inst_arbiter.sv
// Round-robin arbiter sharing one matrix LSU instruction port among NUM_REQ requesters,
// with an in-order ownership queue that routes each LSU completion back to its issuer.
`ifndef BW_DCA_MATRIX_LSU_INST
`define BW_DCA_MATRIX_LSU_INST 32
`endif

module dca_lsu_inst_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BW_INST    = `BW_DCA_MATRIX_LSU_INST,
  parameter int OSTD_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstnn,
  input  logic                          clear,
  input  logic                          enable,
  output logic                          busy,
  output logic [$clog2(OSTD_DEPTH):0]   ostd_num,
  output logic                          err_unexpected_done,
  dca_lsu_inst_arbiter_if.slave         bus
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW  = $clog2(OSTD_DEPTH);
  localparam int CW  = PW + 1;

  logic [IDW-1:0]     r_rr_ptr;
  logic               r_lock;
  logic [IDW-1:0]     r_locked_id;
  logic [IDW-1:0]     r_owner [OSTD_DEPTH];
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [CW-1:0]      r_cnt;
  logic [NUM_REQ-1:0] r_req_done;
  logic               r_err;

  logic [IDW-1:0]     w_scan_id;
  logic [IDW-1:0]     w_grant;
  logic               w_can_issue;
  logic               w_lsu_valid;
  logic               w_xfer;
  logic               w_pop;
  logic               w_unexp;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // Walk from the farthest offset down so the nearest valid to rr_ptr wins.
  always_comb begin
    w_scan_id = r_rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_inst_wvalid[wrap_add(r_rr_ptr, k)]) w_scan_id = wrap_add(r_rr_ptr, k);
    end
  end

  assign w_grant     = r_lock ? r_locked_id : w_scan_id;
  // Holding rstnn in the issue term keeps every output quiet while reset is asserted.
  assign w_can_issue = rstnn & enable & ~clear & (r_cnt != CW'(OSTD_DEPTH));
  assign w_lsu_valid = w_can_issue & bus.req_inst_wvalid[w_grant];
  assign w_xfer      = w_lsu_valid & bus.lsu_inst_wready;
  assign w_pop       = bus.lsu_done & ~clear & (r_cnt != '0);
  assign w_unexp     = bus.lsu_done & ~clear & (r_cnt == '0);

  assign bus.lsu_inst_wvalid = w_lsu_valid;
  assign bus.lsu_inst_wdata  = bus.req_inst_wdata[int'(w_grant)*BW_INST +: BW_INST];

  always_comb begin
    bus.req_inst_wready = '0;
    if (w_xfer) bus.req_inst_wready[w_grant] = 1'b1;
  end

  assign bus.req_done           = r_req_done;
  assign ostd_num               = r_cnt;
  assign err_unexpected_done    = r_err;
  assign busy                   = rstnn & ((|bus.req_inst_wvalid) | (r_cnt != '0));

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_rr_ptr    <= '0;
      r_lock      <= 1'b0;
      r_locked_id <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_req_done  <= '0;
      r_err       <= 1'b0;
      for (int i = 0; i < OSTD_DEPTH; i++) r_owner[i] <= '0;
    end else if (clear) begin
      r_rr_ptr    <= '0;
      r_lock      <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_req_done  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_owner[r_wptr] <= w_grant;
        r_wptr          <= r_wptr + PW'(1);
        r_rr_ptr        <= wrap_add(w_grant, 1);
        r_lock          <= 1'b0;
      end else if (w_lsu_valid) begin
        r_lock      <= 1'b1;
        r_locked_id <= w_grant;
      end

      r_req_done <= '0;
      if (w_pop) begin
        r_req_done[r_owner[r_rptr]] <= 1'b1;
        r_rptr                      <= r_rptr + PW'(1);
      end

      if (w_unexp) r_err <= 1'b1;

      case ({w_xfer, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_dca_lsu_inst_arbiter.sv
// Directed bench for dca_lsu_inst_arbiter: NUM_REQ=4, BW_INST=8, OSTD_DEPTH=4.
// Inputs change 1 time unit after each rising edge; outputs are checked 4 units after it.
module tb_dca_lsu_inst_arbiter;
  localparam int NR = 4;
  localparam int BW = 8;
  localparam int OD = 4;

  logic       clk = 1'b0;
  logic       rstnn = 1'b0;
  logic       clear = 1'b0;
  logic       enable = 1'b0;
  logic       busy;
  logic [2:0] ostd_num;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  dca_lsu_inst_arbiter_if #(.NUM_REQ(NR), .BW_INST(BW)) bus ();

  dca_lsu_inst_arbiter #(.NUM_REQ(NR), .BW_INST(BW), .OSTD_DEPTH(OD)) dut (
    .clk                 (clk),
    .rstnn               (rstnn),
    .clear               (clear),
    .enable              (enable),
    .busy                (busy),
    .ostd_num            (ostd_num),
    .err_unexpected_done (err),
    .bus                 (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_inst_wvalid = '0;
    bus.req_inst_wdata  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.lsu_inst_wready = 1'b1;
    bus.lsu_done        = 1'b0;
    clear               = 1'b0;
    enable              = 1'b1;
  endtask

  task automatic do_clear();
    step();
    idle_inputs();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstnn = 1'b0;
    #2;
    n_cmp++; if (ostd_num !== 3'd0) begin n_bad++; $display("FAIL reset_ostd got %0d want 0", ostd_num); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (bus.lsu_inst_wvalid !== 1'b0) begin n_bad++; $display("FAIL reset_wvalid got %b want 0", bus.lsu_inst_wvalid); end
    n_cmp++; if (bus.req_done !== 4'b0) begin n_bad++; $display("FAIL reset_req_done got %b want 0000", bus.req_done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    step();
    step();
    rstnn = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy, exp_done;
    for (int c = 0; c < 9; c++) begin
      step();
      bus.req_inst_wvalid = (c < 5) ? 4'hF : 4'h0;
      bus.lsu_done        = (c >= 2 && c <= 6);
      #3;
      exp_rdy  = (c < 5) ? 4'(1 << (c % 4)) : 4'h0;
      exp_done = (c >= 3 && c <= 7) ? 4'(1 << ((c - 3) % 4)) : 4'h0;
      n_cmp++; if (bus.req_inst_wready !== exp_rdy) begin n_bad++; $display("FAIL rr_grant cyc %0d got %b want %b", c, bus.req_inst_wready, exp_rdy); end
      if (c < 5) begin
        n_cmp++; if (bus.lsu_inst_wdata !== 8'(8'h10 + c % 4)) begin n_bad++; $display("FAIL rr_wdata cyc %0d got %h want %h", c, bus.lsu_inst_wdata, 8'(8'h10 + c % 4)); end
      end
      n_cmp++; if (bus.req_done !== exp_done) begin n_bad++; $display("FAIL rr_req_done cyc %0d got %b want %b", c, bus.req_done, exp_done); end
    end
    step();
    bus.lsu_done = 1'b0;
    #3;
    n_cmp++; if (ostd_num !== 3'd0) begin n_bad++; $display("FAIL rr_drained_ostd got %0d want 0", ostd_num); end
  endtask

  task automatic test_stall();
    do_clear();
    bus.req_inst_wdata[23:16] = 8'hA5;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step();
      bus.req_inst_wvalid = (c >= 2) ? 4'b0101 : 4'b0100;
      bus.lsu_inst_wready = (c == 3);
      #3;
      n_cmp++; if (bus.lsu_inst_wdata !== 8'hA5) begin n_bad++; $display("FAIL stall_wdata cyc %0d got %h want a5", c, bus.lsu_inst_wdata); end
      n_cmp++; if (bus.lsu_inst_wvalid !== 1'b1) begin n_bad++; $display("FAIL stall_wvalid cyc %0d got %b want 1", c, bus.lsu_inst_wvalid); end
      n_cmp++; if (bus.req_inst_wready !== ((c == 3) ? 4'b0100 : 4'b0000)) begin n_bad++; $display("FAIL stall_wready cyc %0d got %b want %b", c, bus.req_inst_wready, (c == 3) ? 4'b0100 : 4'b0000); end
    end
    step();
    bus.req_inst_wvalid = 4'b0001;
    #3;
    n_cmp++; if (bus.req_inst_wready !== 4'b0001) begin n_bad++; $display("FAIL stall_next_grant got %b want 0001", bus.req_inst_wready); end
    n_cmp++; if (bus.lsu_inst_wdata !== 8'h10) begin n_bad++; $display("FAIL stall_next_wdata got %h want 10", bus.lsu_inst_wdata); end
    step();
    bus.req_inst_wvalid = 4'b0000;
    bus.lsu_done = 1'b1;
    #3;
    n_cmp++; if (ostd_num !== 3'd2) begin n_bad++; $display("FAIL stall_ostd got %0d want 2", ostd_num); end
    step();
    #3;
    n_cmp++; if (bus.req_done !== 4'b0100) begin n_bad++; $display("FAIL stall_done0 got %b want 0100", bus.req_done); end
    step();
    bus.lsu_done = 1'b0;
    #3;
    n_cmp++; if (bus.req_done !== 4'b0001) begin n_bad++; $display("FAIL stall_done1 got %b want 0001", bus.req_done); end
    bus.req_inst_wdata = {8'h13, 8'h12, 8'h11, 8'h10};
  endtask

  task automatic test_full();
    logic [3:0] exp_done;
    do_clear();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step();
      bus.req_inst_wvalid = 4'hF;
      #3;
      n_cmp++; if (bus.req_inst_wready !== 4'(1 << c)) begin n_bad++; $display("FAIL full_fill cyc %0d got %b want %b", c, bus.req_inst_wready, 4'(1 << c)); end
    end
    step();
    bus.req_inst_wvalid = 4'b0010;
    #3;
    n_cmp++; if (ostd_num !== 3'd4) begin n_bad++; $display("FAIL full_ostd got %0d want 4", ostd_num); end
    n_cmp++; if (bus.lsu_inst_wvalid !== 1'b0) begin n_bad++; $display("FAIL full_wvalid got %b want 0", bus.lsu_inst_wvalid); end
    step();
    bus.lsu_done = 1'b1;
    #3;
    n_cmp++; if (bus.lsu_inst_wvalid !== 1'b0) begin n_bad++; $display("FAIL full_pop_same_cycle got %b want 0", bus.lsu_inst_wvalid); end
    step();
    bus.lsu_done = 1'b0;
    #3;
    n_cmp++; if (bus.req_done !== 4'b0001) begin n_bad++; $display("FAIL full_first_done got %b want 0001", bus.req_done); end
    n_cmp++; if (ostd_num !== 3'd3) begin n_bad++; $display("FAIL full_ostd3 got %0d want 3", ostd_num); end
    n_cmp++; if (bus.req_inst_wready !== 4'b0010) begin n_bad++; $display("FAIL full_resume got %b want 0010", bus.req_inst_wready); end
    for (int c = 7; c < 12; c++) begin
      step();
      bus.req_inst_wvalid = 4'b0000;
      bus.lsu_done = (c <= 10);
      #3;
      case (c)
        7:       exp_done = 4'b0000;
        8:       exp_done = 4'b0010;
        9:       exp_done = 4'b0100;
        10:      exp_done = 4'b1000;
        default: exp_done = 4'b0010;
      endcase
      n_cmp++; if (bus.req_done !== exp_done) begin n_bad++; $display("FAIL full_drain cyc %0d got %b want %b", c, bus.req_done, exp_done); end
      if (c == 7) begin
        n_cmp++; if (ostd_num !== 3'd4) begin n_bad++; $display("FAIL full_refill got %0d want 4", ostd_num); end
      end
    end
    n_cmp++; if (ostd_num !== 3'd0) begin n_bad++; $display("FAIL full_empty got %0d want 0", ostd_num); end
  endtask

  task automatic test_wrap();
    logic [3:0] vt [12] = '{4'b1111, 4'b1001, 4'b1010, 4'b0011, 4'b1100, 4'b0110,
                            4'b1111, 4'b0101, 4'b1000, 4'b0010, 4'b0001, 4'b1110};
    int gt [12] = '{0, 3, 1, 0, 2, 1, 2, 0, 3, 1, 0, 1};
    logic [3:0] exp_rdy, exp_done;
    do_clear();
    for (int c = 0; c < 15; c++) begin
      if (c > 0) step();
      bus.req_inst_wvalid = (c < 12) ? vt[c] : 4'h0;
      bus.lsu_done        = (c >= 2 && c <= 13);
      #3;
      exp_rdy  = (c < 12) ? 4'(1 << gt[c]) : 4'h0;
      exp_done = (c >= 3) ? 4'(1 << gt[c - 3]) : 4'h0;
      n_cmp++; if (bus.req_inst_wready !== exp_rdy) begin n_bad++; $display("FAIL wrap_grant cyc %0d got %b want %b", c, bus.req_inst_wready, exp_rdy); end
      if (c < 12) begin
        n_cmp++; if (bus.lsu_inst_wdata !== 8'(8'h10 + gt[c])) begin n_bad++; $display("FAIL wrap_wdata cyc %0d got %h want %h", c, bus.lsu_inst_wdata, 8'(8'h10 + gt[c])); end
      end
      n_cmp++; if (bus.req_done !== exp_done) begin n_bad++; $display("FAIL wrap_owner cyc %0d got %b want %b", c, bus.req_done, exp_done); end
      if (c >= 3 && c <= 12) begin
        n_cmp++; if (ostd_num !== 3'd2) begin n_bad++; $display("FAIL wrap_ostd cyc %0d got %0d want 2", c, ostd_num); end
      end
    end
    step();
    bus.lsu_done = 1'b0;
  endtask

  task automatic test_unexpected_done();
    do_clear();
    bus.req_inst_wvalid = 4'b0100;
    #3;
    n_cmp++; if (bus.req_inst_wready !== 4'b0100) begin n_bad++; $display("FAIL unexp_issue got %b want 0100", bus.req_inst_wready); end
    step();
    bus.req_inst_wvalid = 4'b0000;
    bus.lsu_done = 1'b1;
    step();
    #3;
    n_cmp++; if (bus.req_done !== 4'b0100) begin n_bad++; $display("FAIL unexp_real_done got %b want 0100", bus.req_done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL unexp_err_early got %b want 0", err); end
    step();
    bus.lsu_done = 1'b0;
    #3;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL unexp_err_set got %b want 1", err); end
    n_cmp++; if (bus.req_done !== 4'b0000) begin n_bad++; $display("FAIL unexp_no_done got %b want 0000", bus.req_done); end
    step();
    clear = 1'b1;
    bus.lsu_done = 1'b1;
    bus.req_inst_wvalid = 4'hF;
    #3;
    n_cmp++; if (bus.lsu_inst_wvalid !== 1'b0) begin n_bad++; $display("FAIL clear_blocks_issue got %b want 0", bus.lsu_inst_wvalid); end
    step();
    clear = 1'b0;
    bus.lsu_done = 1'b0;
    #3;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL clear_err got %b want 0", err); end
    n_cmp++; if (ostd_num !== 3'd0) begin n_bad++; $display("FAIL clear_ostd got %0d want 0", ostd_num); end
    n_cmp++; if (bus.req_inst_wready !== 4'b0001) begin n_bad++; $display("FAIL clear_rr_ptr got %b want 0001", bus.req_inst_wready); end
    step();
    bus.req_inst_wvalid = 4'b0000;
    bus.lsu_done = 1'b1;
    step();
    bus.lsu_done = 1'b0;
    #3;
    n_cmp++; if (bus.req_done !== 4'b0001) begin n_bad++; $display("FAIL clear_after_done got %b want 0001", bus.req_done); end
  endtask

  task automatic test_enable_reset();
    do_clear();
    bus.req_inst_wvalid = 4'b0011;
    #3;
    n_cmp++; if (bus.req_inst_wready !== 4'b0001) begin n_bad++; $display("FAIL en_issue0 got %b want 0001", bus.req_inst_wready); end
    step();
    bus.req_inst_wvalid = 4'b0010;
    #3;
    n_cmp++; if (bus.req_inst_wready !== 4'b0010) begin n_bad++; $display("FAIL en_issue1 got %b want 0010", bus.req_inst_wready); end
    step();
    enable = 1'b0;
    bus.req_inst_wvalid = 4'b1000;
    #3;
    n_cmp++; if (bus.lsu_inst_wvalid !== 1'b0) begin n_bad++; $display("FAIL en_off_wvalid got %b want 0", bus.lsu_inst_wvalid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL en_off_busy got %b want 1", busy); end
    n_cmp++; if (ostd_num !== 3'd2) begin n_bad++; $display("FAIL en_off_ostd got %0d want 2", ostd_num); end
    step();
    bus.lsu_done = 1'b1;
    step();
    #3;
    n_cmp++; if (bus.req_done !== 4'b0001) begin n_bad++; $display("FAIL en_off_done0 got %b want 0001", bus.req_done); end
    step();
    bus.lsu_done = 1'b0;
    #3;
    n_cmp++; if (bus.req_done !== 4'b0010) begin n_bad++; $display("FAIL en_off_done1 got %b want 0010", bus.req_done); end
    n_cmp++; if (bus.req_inst_wready !== 4'b0000) begin n_bad++; $display("FAIL en_off_wready got %b want 0000", bus.req_inst_wready); end
    step();
    enable = 1'b1;
    bus.lsu_inst_wready = 1'b0;
    #3;
    n_cmp++; if (bus.lsu_inst_wvalid !== 1'b1) begin n_bad++; $display("FAIL en_on_wvalid got %b want 1", bus.lsu_inst_wvalid); end
    step();
    #3;
    n_cmp++; if (ostd_num !== 3'd0) begin n_bad++; $display("FAIL en_stalled_ostd got %0d want 0", ostd_num); end
    bus.lsu_inst_wready = 1'b1;
    step();
    bus.lsu_inst_wready = 1'b0;
    #3;
    n_cmp++; if (ostd_num !== 3'd1) begin n_bad++; $display("FAIL rst_inflight_ostd got %0d want 1", ostd_num); end
    #1;
    rstnn = 1'b0;
    #1;
    n_cmp++; if (ostd_num !== 3'd0) begin n_bad++; $display("FAIL rst_async_ostd got %0d want 0", ostd_num); end
    n_cmp++; if (bus.lsu_inst_wvalid !== 1'b0) begin n_bad++; $display("FAIL rst_async_wvalid got %b want 0", bus.lsu_inst_wvalid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_async_busy got %b want 0", busy); end
    n_cmp++; if (bus.req_done !== 4'b0000) begin n_bad++; $display("FAIL rst_async_req_done got %b want 0000", bus.req_done); end
    step();
    step();
    bus.req_inst_wvalid = 4'b0000;
    rstnn = 1'b1;
    step();
    bus.lsu_done = 1'b1;
    step();
    bus.lsu_done = 1'b0;
    #3;
    n_cmp++; if (bus.req_done !== 4'b0000) begin n_bad++; $display("FAIL rst_no_stale_done got %b want 0000", bus.req_done); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rst_queue_empty_err got %b want 1", err); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_full();
    test_wrap();
    test_unexpected_done();
    test_enable_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dca_lsu_inst_arbiter.md
Name: dca_lsu_inst_arbiter

Overview:
- Shares one matrix LSU instruction port among NUM_REQ DCA compute modules. Each module issues load and store LSU instructions.
- Grants requesters round-robin and holds the grant stable under LSU backpressure.
- Records the owner of every issued instruction in an in-order ownership queue, so each LSU completion pulse is routed back to the requester that issued it.
- Sits between the DCA module LSU-instruction outputs and the single shared DCA matrix LSU.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BW_INST, `BW_DCA_MATRIX_LSU_INST, width of one LSU instruction
OSTD_DEPTH, 4, maximum outstanding instructions (power of 2, >=2)

Ports:
clk  input  1  clock
rstnn  input  1  asynchronous active-low reset
clear  input  1  synchronous clear; dominates all other inputs
enable  input  1  issue enable; does not gate completion handling
busy  output  1  any requester valid OR outstanding count != 0
req_inst_wvalid  input  NUM_REQ  per-requester instruction valid; must hold valid and data until accepted
req_inst_wready  output  NUM_REQ  per-requester accept; one-hot or zero
req_inst_wdata  input  NUM_REQ*BW_INST  instructions; requester i occupies bits [i*BW_INST +: BW_INST]
req_done  output  NUM_REQ  one-cycle completion pulse to the owning requester
lsu_inst_wvalid  output  1  instruction valid to the LSU
lsu_inst_wready  input  1  LSU accepts the instruction
lsu_inst_wdata  output  BW_INST  selected instruction
lsu_done  input  1  one-cycle pulse per completed instruction; completions arrive in issue order
ostd_num  output  log2(OSTD_DEPTH)+1  current outstanding count
err_unexpected_done  output  1  sticky flag: lsu_done seen while the queue is empty

Behaviour:
- Reset (rstnn=0, asynchronous):
  - rr_ptr=0, lock=0, locked_id=0.
  - Queue empty; ostd_num=0.
  - req_done=0, err_unexpected_done=0.
  - Therefore lsu_inst_wvalid=0, req_inst_wready=0, busy=0.
- Issue condition: can_issue = enable & ~clear & (ostd_num != OSTD_DEPTH). A pop in the same cycle does not free a slot.
- Grant (combinational):
  - If lock=1, grant = locked_id.
  - Otherwise grant is the first i with req_inst_wvalid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Grant depends only on valids, lock and rr_ptr, never on lsu_inst_wready.
- LSU outputs:
  - lsu_inst_wvalid = can_issue & req_inst_wvalid[grant].
  - lsu_inst_wdata = req_inst_wdata slice of grant. The value is don't-care when lsu_inst_wvalid=0.
  - req_inst_wready[i] = lsu_inst_wvalid & lsu_inst_wready & (grant==i).
- Transfer occurs when lsu_inst_wvalid & lsu_inst_wready. On the next edge:
  - Push grant into the ownership queue.
  - rr_ptr = (grant+1) mod NUM_REQ.
  - lock = 0.
- Lock:
  - If lsu_inst_wvalid=1 and lsu_inst_wready=0, set lock=1 and locked_id=grant at the next edge.
  - The lock keeps lsu_inst_wdata stable until the transfer.
  - If can_issue drops while locked (enable=0 or queue full), the lock is retained.
  - The lock releases only on transfer or clear.
- Completion:
  - lsu_done with the queue non-empty pops the head owner h. req_done[h]=1 in the next cycle (registered, 1-cycle latency), otherwise 0.
  - Exactly one req_done bit pulses per lsu_done.
  - lsu_done with the queue empty is ignored, except that it sets err_unexpected_done=1.
- Simultaneous push and pop: both take effect; ostd_num is unchanged; queue order is preserved. The pointers wrap modulo OSTD_DEPTH.
- ostd_num updates the cycle after push or pop. It never exceeds OSTD_DEPTH and never underflows.
- clear=1 at an edge:
  - Empties the queue; sets rr_ptr=0, lock=0, req_done=0, err_unexpected_done=0.
  - No transfer happens that cycle, because can_issue=0.
  - A lsu_done arriving in the clear cycle is dropped.
- enable=0: no new transfers. Pending lsu_done pulses are still popped and reported.
- Reset asserted mid-transfer: all state returns to reset values immediately; no req_done is produced for in-flight instructions.

Test Plan:
- NUM_REQ=4, all four valid continuously, lsu_inst_wready=1, lsu_done 2 cycles after each issue -> grants 0,1,2,3,0 on consecutive cycles; req_done pulses 3 cycles after each issue, in order 0,1,2,3.
- Req2 valid with data 0xA5, lsu_inst_wready=0 for 3 cycles; req0 becomes valid in cycle 2 -> lsu_inst_wdata stays 0xA5 and grant stays 2 through the stall; transfer on ready; req0 is granted next.
- OSTD_DEPTH=4, 4 issues with no lsu_done -> ostd_num=4 and lsu_inst_wvalid=0 while req1 is valid; one lsu_done -> req_done[owner of issue 1] pulses; issue resumes 1 cycle after ostd_num=3.
- Push and pop in the same cycle with ostd_num=2 -> ostd_num remains 2 and the owner sequence stays FIFO-correct across wrap (≥10 issues).
- lsu_done with the queue empty -> err_unexpected_done=1 and no req_done; then clear=1 -> err=0, ostd_num=0, rr_ptr=0.
- enable=0 with 2 outstanding and req3 valid -> no issue; both lsu_done pulses still produce req_done; rstnn pulsed low mid-stream -> all outputs 0 asynchronously.
